instruction_decode: RTL and testbench

RV32I decode stage sitting between the fetch stage and the execute stage. Consumes the IF/ID instruction and PC, reads the 32×32 register file, generates immediates and control, and registers everything into the ID/EX pipeline register. Detects load-use hazards, driving the fetch stall input, and flushes on a taken branch from execute.

---
 rtl/riscv_pkg.sv | 82 ++++++++
 rtl/instruction_decode_regfile.sv | 37 +++
 rtl/instruction_decode.sv | 218 +++++++++++++++++++++
 tb/tb_instruction_decode.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I constants and types for the decode stage.
// Holds opcodes, ALU/jump encodings, the ID/EX record and the immediate generator.
package riscv_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;

    localparam logic [31:0] INSTR_NOP = 32'h00000013;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_PASSB = 4'd10
    } alu_op_e;

    typedef enum logic [1:0] {
        JUMP_NONE = 2'd0,
        JUMP_JAL  = 2'd1,
        JUMP_JALR = 2'd2
    } jump_e;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J,
        FMT_NONE
    } fmt_e;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        alu_op_e     alu_op;
        logic        alu_src_imm;
        logic        alu_src_pc;
        logic        mem_read;
        logic        mem_write;
        logic        reg_write;
        logic        branch;
        jump_e       jump;
        logic        illegal;
    } idex_t;

    function automatic logic [31:0] gen_imm(input fmt_e fmt, input logic [31:0] instr);
        logic [31:0] imm;
        case (fmt)
            FMT_I:   imm = {{20{instr[31]}}, instr[31:20]};
            FMT_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            FMT_U:   imm = {instr[31:12], 12'b0};
            FMT_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = 32'd0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/instruction_decode_regfile.sv
// 32x32 register file: two combinational reads, one synchronous write.
// x0 reads as zero; a read of the register being written returns the write data.
module regfile (
    input  logic        clk_i,
    input  logic [4:0]  rs1_addr_i,
    input  logic [4:0]  rs2_addr_i,
    input  logic        wr_en_i,
    input  logic [4:0]  wr_addr_i,
    input  logic [31:0] wr_data_i,
    output logic [31:0] rs1_data_o,
    output logic [31:0] rs2_data_o
);

    logic [31:0] regs_q [32];

    always_ff @(posedge clk_i) begin
        if (wr_en_i && (wr_addr_i != 5'd0)) begin
            regs_q[wr_addr_i] <= wr_data_i;
        end
    end

    function automatic logic [31:0] read_port(input logic [4:0] addr);
        logic [31:0] data;
        if (addr == 5'd0) begin
            data = 32'd0;
        end else if (wr_en_i && (wr_addr_i == addr)) begin
            data = wr_data_i;
        end else begin
            data = regs_q[addr];
        end
        return data;
    endfunction

    assign rs1_data_o = read_port(rs1_addr_i);
    assign rs2_data_o = read_port(rs2_addr_i);

endmodule

// File: rtl/instruction_decode.sv
// RV32I decode stage: field decode, immediates, load-use hazard and the ID/EX register.
// Build option DECODE_ILLEGAL_FLAG_EN: flag illegal encodings instead of dropping them as bubbles.
module instruction_decode
    import riscv_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] instruction_id_i,
    input  logic [31:0] pc_id_i,
    input  logic        branching_i,
    input  logic        reg_wr_en_wb_i,
    input  logic [4:0]  rd_wb_i,
    input  logic [31:0] rd_data_wb_i,
    output logic        load_stall_id_o,
    output logic        valid_id_o,
    output logic [31:0] pc_id_o,
    output logic [31:0] rs1_data_id_o,
    output logic [31:0] rs2_data_id_o,
    output logic [31:0] imm_id_o,
    output logic [4:0]  rs1_id_o,
    output logic [4:0]  rs2_id_o,
    output logic [4:0]  rd_id_o,
    output logic [2:0]  funct3_id_o,
    output logic [3:0]  alu_op_id_o,
    output logic        alu_src_imm_id_o,
    output logic        alu_src_pc_id_o,
    output logic        mem_read_id_o,
    output logic        mem_write_id_o,
    output logic        reg_write_id_o,
    output logic        branch_id_o,
    output logic [1:0]  jump_id_o,
    output logic        illegal_instr_id_o
);

    idex_t idex_q, idex_d, dec;

    logic [6:0]  opcode;
    logic [4:0]  rd_f, rs1_f, rs2_f;
    logic [2:0]  funct3_f;
    logic [6:0]  funct7_f;
    logic [31:0] rs1_rdata, rs2_rdata;

    assign opcode   = instruction_id_i[6:0];
    assign rd_f     = instruction_id_i[11:7];
    assign funct3_f = instruction_id_i[14:12];
    assign rs1_f    = instruction_id_i[19:15];
    assign rs2_f    = instruction_id_i[24:20];
    assign funct7_f = instruction_id_i[31:25];

    regfile u_regfile (
        .clk_i      (clk_i),
        .rs1_addr_i (rs1_f),
        .rs2_addr_i (rs2_f),
        .wr_en_i    (reg_wr_en_wb_i),
        .wr_addr_i  (rd_wb_i),
        .wr_data_i  (rd_data_wb_i),
        .rs1_data_o (rs1_rdata),
        .rs2_data_o (rs2_rdata)
    );

    fmt_e    fmt;
    alu_op_e alu_op;
    jump_e   jump;
    logic    legal, src_imm, src_pc, mem_read, mem_write, reg_write, branch;
    logic    rs1_used, rs2_used, rd_used, bubble_in, hazard;

    always_comb begin
        fmt       = FMT_NONE;
        alu_op    = ALU_ADD;
        jump      = JUMP_NONE;
        legal     = 1'b1;
        src_imm   = 1'b0;
        src_pc    = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        reg_write = 1'b0;
        branch    = 1'b0;
        case (opcode)
            OPC_LUI: begin
                fmt = FMT_U; alu_op = ALU_PASSB; src_imm = 1'b1; reg_write = 1'b1;
            end
            OPC_AUIPC: begin
                fmt = FMT_U; src_imm = 1'b1; src_pc = 1'b1; reg_write = 1'b1;
            end
            OPC_JAL: begin
                fmt = FMT_J; src_imm = 1'b1; src_pc = 1'b1; reg_write = 1'b1; jump = JUMP_JAL;
            end
            OPC_JALR: begin
                fmt = FMT_I; src_imm = 1'b1; src_pc = 1'b1; reg_write = 1'b1; jump = JUMP_JALR;
                legal = (funct3_f == 3'b000);
            end
            OPC_BRANCH: begin
                fmt = FMT_B; alu_op = ALU_SUB; branch = 1'b1;
                legal = (funct3_f != 3'b010) && (funct3_f != 3'b011);
            end
            OPC_LOAD: begin
                fmt = FMT_I; src_imm = 1'b1; mem_read = 1'b1; reg_write = 1'b1;
                legal = (funct3_f inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
            end
            OPC_STORE: begin
                fmt = FMT_S; src_imm = 1'b1; mem_write = 1'b1;
                legal = (funct3_f inside {3'b000, 3'b001, 3'b010});
            end
            OPC_OP_IMM: begin
                fmt = FMT_I; src_imm = 1'b1; reg_write = 1'b1;
                case (funct3_f)
                    3'b000: alu_op = ALU_ADD;
                    3'b010: alu_op = ALU_SLT;
                    3'b011: alu_op = ALU_SLTU;
                    3'b100: alu_op = ALU_XOR;
                    3'b110: alu_op = ALU_OR;
                    3'b111: alu_op = ALU_AND;
                    3'b001: begin
                        alu_op = ALU_SLL;
                        legal  = (funct7_f == 7'b0000000);
                    end
                    default: begin
                        alu_op = (funct7_f == 7'b0100000) ? ALU_SRA : ALU_SRL;
                        legal  = (funct7_f == 7'b0000000) || (funct7_f == 7'b0100000);
                    end
                endcase
            end
            OPC_OP: begin
                fmt = FMT_R; reg_write = 1'b1;
                case ({funct7_f, funct3_f})
                    {7'b0000000, 3'b000}: alu_op = ALU_ADD;
                    {7'b0100000, 3'b000}: alu_op = ALU_SUB;
                    {7'b0000000, 3'b001}: alu_op = ALU_SLL;
                    {7'b0000000, 3'b010}: alu_op = ALU_SLT;
                    {7'b0000000, 3'b011}: alu_op = ALU_SLTU;
                    {7'b0000000, 3'b100}: alu_op = ALU_XOR;
                    {7'b0000000, 3'b101}: alu_op = ALU_SRL;
                    {7'b0100000, 3'b101}: alu_op = ALU_SRA;
                    {7'b0000000, 3'b110}: alu_op = ALU_OR;
                    {7'b0000000, 3'b111}: alu_op = ALU_AND;
                    default:              legal  = 1'b0;
                endcase
            end
            OPC_FENCE: fmt = FMT_I;
            default:   legal = 1'b0;
        endcase
    end

    // Unused operand/destination fields are zeroed so forwarding never sees false matches.
    assign rs1_used  = legal && (fmt inside {FMT_R, FMT_I, FMT_S, FMT_B});
    assign rs2_used  = legal && (fmt inside {FMT_R, FMT_S, FMT_B});
    assign rd_used   = legal && (fmt inside {FMT_R, FMT_I, FMT_U, FMT_J});
    assign bubble_in = (instruction_id_i == 32'd0) || (instruction_id_i == INSTR_NOP);

    always_comb begin
        dec = '0;
        if (legal) begin
            dec.valid       = 1'b1;
            dec.pc          = pc_id_i;
            dec.rs1         = rs1_used ? rs1_f : 5'd0;
            dec.rs2         = rs2_used ? rs2_f : 5'd0;
            dec.rs1_data    = rs1_used ? rs1_rdata : 32'd0;
            dec.rs2_data    = rs2_used ? rs2_rdata : 32'd0;
            dec.rd          = rd_used ? rd_f : 5'd0;
            dec.funct3      = rs1_used ? funct3_f : 3'd0;
            dec.imm         = gen_imm(fmt, instruction_id_i);
            dec.alu_op      = alu_op;
            dec.alu_src_imm = src_imm;
            dec.alu_src_pc  = src_pc;
            dec.mem_read    = mem_read;
            dec.mem_write   = mem_write;
            dec.reg_write   = reg_write && (rd_f != 5'd0);
            dec.branch      = branch;
            dec.jump        = jump;
        end else begin
`ifdef DECODE_ILLEGAL_FLAG_EN
            dec.valid   = 1'b1;
            dec.pc      = pc_id_i;
            dec.illegal = 1'b1;
`endif
        end
    end

    assign hazard = idex_q.mem_read && idex_q.valid && (idex_q.rd != 5'd0) &&
                    ((rs1_used && (idex_q.rd == rs1_f)) || (rs2_used && (idex_q.rd == rs2_f)));
    // Fetch holds its PC on a stall, so a stall must never mask a branch redirect.
    assign load_stall_id_o = hazard && !branching_i;

    always_comb begin
        idex_d = dec;
        if (branching_i || load_stall_id_o || bubble_in) begin
            idex_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            idex_q <= '0;
        end else begin
            idex_q <= idex_d;
        end
    end

    assign valid_id_o         = idex_q.valid;
    assign pc_id_o            = idex_q.pc;
    assign rs1_data_id_o      = idex_q.rs1_data;
    assign rs2_data_id_o      = idex_q.rs2_data;
    assign imm_id_o           = idex_q.imm;
    assign rs1_id_o           = idex_q.rs1;
    assign rs2_id_o           = idex_q.rs2;
    assign rd_id_o            = idex_q.rd;
    assign funct3_id_o        = idex_q.funct3;
    assign alu_op_id_o        = idex_q.alu_op;
    assign alu_src_imm_id_o   = idex_q.alu_src_imm;
    assign alu_src_pc_id_o    = idex_q.alu_src_pc;
    assign mem_read_id_o      = idex_q.mem_read;
    assign mem_write_id_o     = idex_q.mem_write;
    assign reg_write_id_o     = idex_q.reg_write;
    assign branch_id_o        = idex_q.branch;
    assign jump_id_o          = idex_q.jump;
    assign illegal_instr_id_o = idex_q.illegal;

endmodule

// File: tb/tb_instruction_decode.sv
// Directed bench for instruction_decode: expected ID/EX records queued at drive time,
// popped and compared one cycle later; the load-stall output is compared combinationally.
module tb_instruction_decode;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] instruction_id_i, pc_id_i, rd_data_wb_i;
    logic        branching_i, reg_wr_en_wb_i;
    logic [4:0]  rd_wb_i;
    logic        load_stall_id_o, valid_id_o;
    logic [31:0] pc_id_o, rs1_data_id_o, rs2_data_id_o, imm_id_o;
    logic [4:0]  rs1_id_o, rs2_id_o, rd_id_o;
    logic [2:0]  funct3_id_o;
    logic [3:0]  alu_op_id_o;
    logic        alu_src_imm_id_o, alu_src_pc_id_o, mem_read_id_o, mem_write_id_o;
    logic        reg_write_id_o, branch_id_o, illegal_instr_id_o;
    logic [1:0]  jump_id_o;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic [3:0]  alu_op;
        logic [7:0]  ctl;   // {src_imm, src_pc, mem_read, mem_write, reg_write, branch, jump[1:0]}
        logic        illegal;
    } exp_t;

    localparam exp_t BUB = '0;

    exp_t sb_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk_i = ~clk_i;

    instruction_decode dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .instruction_id_i   (instruction_id_i),
        .pc_id_i            (pc_id_i),
        .branching_i        (branching_i),
        .reg_wr_en_wb_i     (reg_wr_en_wb_i),
        .rd_wb_i            (rd_wb_i),
        .rd_data_wb_i       (rd_data_wb_i),
        .load_stall_id_o    (load_stall_id_o),
        .valid_id_o         (valid_id_o),
        .pc_id_o            (pc_id_o),
        .rs1_data_id_o      (rs1_data_id_o),
        .rs2_data_id_o      (rs2_data_id_o),
        .imm_id_o           (imm_id_o),
        .rs1_id_o           (rs1_id_o),
        .rs2_id_o           (rs2_id_o),
        .rd_id_o            (rd_id_o),
        .funct3_id_o        (funct3_id_o),
        .alu_op_id_o        (alu_op_id_o),
        .alu_src_imm_id_o   (alu_src_imm_id_o),
        .alu_src_pc_id_o    (alu_src_pc_id_o),
        .mem_read_id_o      (mem_read_id_o),
        .mem_write_id_o     (mem_write_id_o),
        .reg_write_id_o     (reg_write_id_o),
        .branch_id_o        (branch_id_o),
        .jump_id_o          (jump_id_o),
        .illegal_instr_id_o (illegal_instr_id_o)
    );

    function automatic exp_t mk(input logic [31:0] pc, rs1d, rs2d, imm,
                                input logic [4:0] rs1, rs2, rd, input logic [2:0] f3,
                                input logic [3:0] alu, input logic [7:0] ctl);
        exp_t e;
        e = '0;
        e.valid = 1'b1; e.pc = pc; e.rs1_data = rs1d; e.rs2_data = rs2d; e.imm = imm;
        e.rs1 = rs1; e.rs2 = rs2; e.rd = rd; e.funct3 = f3; e.alu_op = alu; e.ctl = ctl;
        return e;
    endfunction

    function automatic exp_t illegal_exp(input logic [31:0] pc);
        exp_t e;
        e = '0;
`ifdef DECODE_ILLEGAL_FLAG_EN
        e.valid = 1'b1; e.pc = pc; e.illegal = 1'b1;
`else
        e.pc = pc ^ pc;
`endif
        return e;
    endfunction

    task automatic apply(input string tag, input logic rst, input logic [31:0] instr, pc,
                         input logic br, input logic wbe, input logic [4:0] wrd,
                         input logic [31:0] wdata, input logic exp_stall, input exp_t exp);
        exp_t got, want;
        @(negedge clk_i);
        rst_i = rst; instruction_id_i = instr; pc_id_i = pc; branching_i = br;
        reg_wr_en_wb_i = wbe; rd_wb_i = wrd; rd_data_wb_i = wdata;
        #1;
        vectors++;
        assert (load_stall_id_o === exp_stall) else begin
            miscompares++;
            $error("FAIL %s/stall observed=%0b expected=%0b", tag, load_stall_id_o, exp_stall);
        end
        sb_q.push_back(exp);
        @(posedge clk_i);
        #1;
        got.valid = valid_id_o; got.pc = pc_id_o; got.rs1_data = rs1_data_id_o;
        got.rs2_data = rs2_data_id_o; got.imm = imm_id_o; got.rs1 = rs1_id_o;
        got.rs2 = rs2_id_o; got.rd = rd_id_o; got.funct3 = funct3_id_o; got.alu_op = alu_op_id_o;
        got.ctl = {alu_src_imm_id_o, alu_src_pc_id_o, mem_read_id_o, mem_write_id_o,
                   reg_write_id_o, branch_id_o, jump_id_o};
        got.illegal = illegal_instr_id_o;
        want = sb_q.pop_front();
        vectors++;
        assert (got === want) else begin
            miscompares++;
            $error("FAIL %s/idex observed=%h expected=%h", tag, got, want);
        end
    endtask

    localparam logic [31:0] NOP  = 32'h00000013;
    localparam logic [31:0] LW6  = 32'h0000A303;   // lw x6,0(x1)
    localparam logic [31:0] ADD7 = 32'h002303B3;   // add x7,x6,x2
    localparam logic [31:0] ADD4 = 32'h00018233;   // add x4,x3,x0

    initial begin
        rst_i = 1'b1; instruction_id_i = NOP; pc_id_i = '0; branching_i = 1'b0;
        reg_wr_en_wb_i = 1'b0; rd_wb_i = '0; rd_data_wb_i = '0;

        apply("reset0", 1, NOP, 32'h0, 0, 0, 0, 0, 0, BUB);
        apply("reset1", 1, NOP, 32'h0, 0, 0, 0, 0, 0, BUB);

        apply("wb_x1", 0, NOP, 32'h0, 0, 1, 5'd1, 32'h00001000, 0, BUB);
        apply("wb_x2", 0, NOP, 32'h0, 0, 1, 5'd2, 32'h00000022, 0, BUB);
        apply("wb_x3", 0, NOP, 32'h0, 0, 1, 5'd3, 32'h00000033, 0, BUB);
        apply("wb_x6", 0, 32'h0, 32'h0, 0, 1, 5'd6, 32'h00000066, 0, BUB);

        apply("addi", 0, 32'hFFD00293, 32'h40, 0, 0, 0, 0, 0,
              mk(32'h40, 0, 0, 32'hFFFFFFFD, 0, 0, 5, 0, 0, 8'b1000_1000));

        apply("lw", 0, LW6, 32'h44, 0, 0, 0, 0, 0,
              mk(32'h44, 32'h1000, 0, 0, 1, 0, 6, 2, 0, 8'b1010_1000));
        apply("use_stall", 0, ADD7, 32'h48, 0, 0, 0, 0, 1, BUB);
        apply("use_redo", 0, ADD7, 32'h48, 0, 0, 0, 0, 0,
              mk(32'h48, 32'h66, 32'h22, 0, 6, 2, 7, 0, 0, 8'b0000_1000));

        apply("lw_b", 0, LW6, 32'h4C, 0, 0, 0, 0, 0,
              mk(32'h4C, 32'h1000, 0, 0, 1, 0, 6, 2, 0, 8'b1010_1000));
        apply("br_beats_stall", 0, ADD7, 32'h50, 1, 0, 0, 0, 0, BUB);
        apply("after_branch", 0, ADD7, 32'h50, 0, 0, 0, 0, 0,
              mk(32'h50, 32'h66, 32'h22, 0, 6, 2, 7, 0, 0, 8'b0000_1000));

        apply("bypass", 0, ADD4, 32'h54, 0, 1, 5'd3, 32'hCAFEF00D, 0,
              mk(32'h54, 32'hCAFEF00D, 0, 0, 3, 0, 4, 0, 0, 8'b0000_1000));
        apply("x0_write", 0, 32'h00000233, 32'h58, 0, 1, 5'd0, 32'hDEADBEEF, 0,
              mk(32'h58, 0, 0, 0, 0, 0, 4, 0, 0, 8'b0000_1000));
        apply("x3_stored", 0, ADD4, 32'h5C, 0, 0, 0, 0, 0,
              mk(32'h5C, 32'hCAFEF00D, 0, 0, 3, 0, 4, 0, 0, 8'b0000_1000));

        apply("illegal_ff", 0, 32'hFFFFFFFF, 32'h60, 0, 0, 0, 0, 0, illegal_exp(32'h60));
        apply("illegal_slli", 0, 32'h40001093, 32'h64, 0, 0, 0, 0, 0, illegal_exp(32'h64));

        apply("beq", 0, 32'hFE208EE3, 32'h68, 0, 0, 0, 0, 0,
              mk(32'h68, 32'h1000, 32'h22, 32'hFFFFFFFC, 1, 2, 0, 0, 1, 8'b0000_0100));
        apply("lui", 0, 32'h12345437, 32'h6C, 0, 0, 0, 0, 0,
              mk(32'h6C, 0, 0, 32'h12345000, 0, 0, 8, 0, 10, 8'b1000_1000));
        apply("jal", 0, 32'h008000EF, 32'h70, 0, 0, 0, 0, 0,
              mk(32'h70, 0, 0, 32'h8, 0, 0, 1, 0, 0, 8'b1100_1001));
        apply("sw", 0, 32'h0020A423, 32'h74, 0, 0, 0, 0, 0,
              mk(32'h74, 32'h1000, 32'h22, 32'h8, 1, 2, 0, 2, 0, 8'b1001_0000));
        apply("addi_x0", 0, 32'h00508013, 32'h78, 0, 0, 0, 0, 0,
              mk(32'h78, 32'h1000, 0, 32'h5, 1, 0, 0, 0, 0, 8'b1000_0000));
        apply("sub", 0, 32'h40208233, 32'h7C, 0, 0, 0, 0, 0,
              mk(32'h7C, 32'h1000, 32'h22, 0, 1, 2, 4, 0, 1, 8'b0000_1000));
        apply("fence", 0, 32'h0000000F, 32'h80, 0, 0, 0, 0, 0,
              mk(32'h80, 0, 0, 0, 0, 0, 0, 0, 0, 8'b0000_0000));
        apply("zero_bubble", 0, 32'h00000000, 32'h84, 0, 0, 0, 0, 0, BUB);

        apply("lw_c", 0, LW6, 32'h88, 0, 0, 0, 0, 0,
              mk(32'h88, 32'h1000, 0, 0, 1, 0, 6, 2, 0, 8'b1010_1000));
        apply("rst_mid_stall", 1, ADD7, 32'h8C, 0, 0, 0, 0, 1, BUB);
        apply("post_rst", 0, ADD7, 32'h8C, 0, 0, 0, 0, 0,
              mk(32'h8C, 32'h66, 32'h22, 0, 6, 2, 7, 0, 0, 8'b0000_1000));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
